// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the mic frame aligner
//
// Purpose: holds the collector state enum, the default sample-array type
// and a counter-width helper used by mic_frame_aligner and frame_mixer.
// Ports: none (package).
package audio_pkg;

    // Default geometry; the modules take these as parameter defaults.
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_WIDTH  = 16;

    // Collector state: IDLE has no channel captured, COLLECT holds a partial
    // frame, TIMEOUT_FLUSH is the single cycle after a partial was discarded.
    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_COLLECT       = 2'd1,
        ST_TIMEOUT_FLUSH = 2'd2
    } align_state_e;

    // One aligned frame at the default geometry, channel i in slot i.
    typedef logic signed [DEF_WIDTH-1:0] sample_arr_t [DEF_NUM_CH];

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frame_mixer.sv
// rtl/frame_mixer.sv - registered full-precision signed sum of one frame
//
// Purpose: sums all channel samples of the frame being loaded and registers
// the result on load_in, so mix_out lines up with the aligned frame register.
// Ports:
//   audio_clk  - clock
//   rst_in     - asynchronous active-high reset, clears mix_out
//   load_in    - capture the sum of samples_in this cycle
//   samples_in - NUM_CH x WIDTH samples (two's complement)
//   mix_out    - registered sum, WIDTH+clog2(NUM_CH) bits, never saturates
module frame_mixer
    import audio_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MIX_W  = WIDTH + $clog2(NUM_CH)
) (
    input  logic                           audio_clk,
    input  logic                           rst_in,
    input  logic                           load_in,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   samples_in,
    output logic signed [MIX_W-1:0]        mix_out
);

    logic signed [MIX_W-1:0] sum_d;
    logic signed [MIX_W-1:0] mix_q;

    // Each sample is sign-extended to the full mix width before adding, so
    // the sum of NUM_CH samples can never wrap.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_d = sum_d + MIX_W'($signed(samples_in[i]));
        end
    end

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            mix_q <= '0;
        end else if (load_in) begin
            mix_q <= sum_d;
        end
    end

    assign mix_out = mix_q;

endmodule

// File: rtl/mic_frame_aligner.sv
// rtl/mic_frame_aligner.sv - aligns independent mic channel strobes into frames
//
// Purpose: collects one sample per channel into a frame, decimates complete
// frames, and presents kept frames plus their mix on a valid/ready output.
// Ports:
//   audio_clk       - clock for all logic
//   rst_in          - asynchronous active-high reset
//   ch_valid_in     - per-channel one-cycle sample strobe
//   ch_data_in      - per-channel signed sample
//   frame_ready_in  - downstream accepts the held frame
//   frame_valid_out - aligned frame available
//   frame_data_out  - aligned samples, channel i in slot i
//   mix_out         - signed sum of the frame's samples
//   frame_count_out - frames loaded into the output register (wraps at 2^16)
//   overrun_out     - sticky: data lost to a repeat or to backpressure
//   timeout_out     - sticky: a partial frame was discarded
//   clear_flags_in  - clears both sticky flags (a same-cycle set wins)
module mic_frame_aligner
    import audio_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DECIM   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                                   audio_clk,
    input  logic                                   rst_in,
    input  logic [NUM_CH-1:0]                      ch_valid_in,
    input  logic [NUM_CH-1:0][WIDTH-1:0]           ch_data_in,
    input  logic                                   frame_ready_in,
    output logic                                   frame_valid_out,
    output logic [NUM_CH-1:0][WIDTH-1:0]           frame_data_out,
    output logic signed [WIDTH+$clog2(NUM_CH)-1:0] mix_out,
    output logic [15:0]                            frame_count_out,
    output logic                                   overrun_out,
    output logic                                   timeout_out,
    input  logic                                   clear_flags_in
);

    localparam int MIX_W = WIDTH + $clog2(NUM_CH);
    localparam int TW    = cnt_width(TIMEOUT);
    localparam int DW    = cnt_width(DECIM);

    align_state_e                 state_q, state_d;
    logic [NUM_CH-1:0]            got_q, got_d;
    logic [NUM_CH-1:0][WIDTH-1:0] cap_q, cap_d;
    logic [TW-1:0]                tcnt_q, tcnt_d;
    logic [DW-1:0]                dec_q, dec_d;
    logic                         fv_q, fv_d;
    logic [NUM_CH-1:0][WIDTH-1:0] fdata_q, fdata_d;
    logic [15:0]                  fcnt_q, fcnt_d;
    logic                         ovr_q, ovr_d;
    logic                         tmo_q, tmo_d;

    logic [NUM_CH-1:0]            vld;
    logic [NUM_CH-1:0][WIDTH-1:0] frame;
    logic                         complete;
    logic                         timed_out;
    logic                         load;
    logic                         ovr_set;
    logic                         tmo_set;

    always_comb begin
        state_d   = state_q;
        got_d     = got_q;
        tcnt_d    = tcnt_q;
        dec_d     = dec_q;
        fv_d      = fv_q;
        fdata_d   = fdata_q;
        fcnt_d    = fcnt_q;
        load      = 1'b0;
        tmo_set   = 1'b0;

        // Strobes landing in the flush cycle belong to the discarded frame.
        vld = (state_q == ST_TIMEOUT_FLUSH) ? '0 : ch_valid_in;

        // Frame as it stands this cycle: newest data wins per channel.
        frame = cap_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (vld[i]) begin
                frame[i] = ch_data_in[i];
            end
        end
        cap_d = frame;

        complete  = &(got_q | vld);
        ovr_set   = |(got_q & vld);
        timed_out = !complete && (got_q != '0) && (tcnt_q >= TW'(TIMEOUT - 1));

        if (fv_q && frame_ready_in) begin
            fv_d = 1'b0;
        end

        if (complete) begin
            got_d   = '0;
            tcnt_d  = '0;
            state_d = ST_IDLE;
            dec_d   = (dec_q == DW'(DECIM - 1)) ? '0 : dec_q + 1'b1;
            if (dec_q == '0) begin
                // Load when empty or when the held frame leaves this cycle.
                if (!fv_q || frame_ready_in) begin
                    load    = 1'b1;
                    fv_d    = 1'b1;
                    fdata_d = frame;
                    fcnt_d  = fcnt_q + 16'd1;
                end else begin
                    ovr_set = 1'b1;
                end
            end
        end else if (timed_out) begin
            got_d   = '0;
            tcnt_d  = '0;
            tmo_set = 1'b1;
            state_d = ST_TIMEOUT_FLUSH;
        end else begin
            got_d   = got_q | vld;
            // Counting starts on the cycle the first strobe of a frame lands.
            tcnt_d  = (got_d != '0) ? tcnt_q + 1'b1 : '0;
            state_d = (got_d != '0) ? ST_COLLECT : ST_IDLE;
        end

        ovr_d = ovr_set ? 1'b1 : (clear_flags_in ? 1'b0 : ovr_q);
        tmo_d = tmo_set ? 1'b1 : (clear_flags_in ? 1'b0 : tmo_q);
    end

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            got_q   <= '0;
            cap_q   <= '0;
            tcnt_q  <= '0;
            dec_q   <= '0;
            fv_q    <= 1'b0;
            fdata_q <= '0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            cap_q   <= cap_d;
            tcnt_q  <= tcnt_d;
            dec_q   <= dec_d;
            fv_q    <= fv_d;
            fdata_q <= fdata_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    frame_mixer #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .MIX_W  (MIX_W)
    ) u_mixer (
        .audio_clk  (audio_clk),
        .rst_in     (rst_in),
        .load_in    (load),
        .samples_in (frame),
        .mix_out    (mix_out)
    );

    assign frame_valid_out = fv_q;
    assign frame_data_out  = fdata_q;
    assign frame_count_out = fcnt_q;
    assign overrun_out     = ovr_q;
    assign timeout_out     = tmo_q;

endmodule

// File: tb/tb_mic_frame_aligner.sv
// tb/tb_mic_frame_aligner.sv - self-checking bench for mic_frame_aligner
module tb_mic_frame_aligner;
    import audio_pkg::*;

    typedef struct {
        logic signed [15:0] d0, d1, d2;
        logic signed [17:0] mix;
    } exp_t;

    typedef struct {
        sample_arr_t        s;
        logic signed [17:0] mix;
    } vec_t;

    logic                    clk;
    logic                    rst;
    logic [2:0]              vld;
    logic [2:0][15:0]        data;
    logic                    ready;
    logic                    clr;

    logic                    a_fv, b_fv;
    logic [2:0][15:0]        a_data, b_data;
    logic signed [17:0]      a_mix, b_mix_o;
    logic [15:0]             a_cnt, b_cnt;
    logic                    a_ovr, b_ovr, a_tmo, b_tmo;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   b_n;
    logic signed [17:0] b_mix [4];
    vec_t tbl [5];

    mic_frame_aligner #(.NUM_CH(3), .WIDTH(16), .DECIM(1), .TIMEOUT(16)) dut_a (
        .audio_clk(clk), .rst_in(rst), .ch_valid_in(vld), .ch_data_in(data),
        .frame_ready_in(ready), .frame_valid_out(a_fv), .frame_data_out(a_data),
        .mix_out(a_mix), .frame_count_out(a_cnt), .overrun_out(a_ovr),
        .timeout_out(a_tmo), .clear_flags_in(clr)
    );

    mic_frame_aligner #(.NUM_CH(3), .WIDTH(16), .DECIM(2), .TIMEOUT(16)) dut_b (
        .audio_clk(clk), .rst_in(rst), .ch_valid_in(vld), .ch_data_in(data),
        .frame_ready_in(ready), .frame_valid_out(b_fv), .frame_data_out(b_data),
        .mix_out(b_mix_o), .frame_count_out(b_cnt), .overrun_out(b_ovr),
        .timeout_out(b_tmo), .clear_flags_in(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [17:0] msum(input logic signed [15:0] d0, d1, d2);
        return 18'(d0) + 18'(d1) + 18'(d2);
    endfunction

    task automatic push(input logic signed [15:0] d0, d1, d2, input logic signed [17:0] m);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.d2 = d2; e.mix = m;
        q.push_back(e);
    endtask

    task automatic sb_pop();
        exp_t e;
        if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected: got frame mix %0d expected none", a_mix);
        end else begin
            e = q.pop_front();
            chk("sb_d0",  $signed(a_data[0]), e.d0);
            chk("sb_d1",  $signed(a_data[1]), e.d1);
            chk("sb_d2",  $signed(a_data[2]), e.d2);
            chk("sb_mix", a_mix, e.mix);
        end
    endtask

    // Samples handshakes on the falling edge, then returns just after the
    // next rising edge, where the bench drives its next inputs.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (a_fv && ready) sb_pop();
            if (b_fv && ready) begin
                if (b_n < 4) b_mix[b_n] = b_mix_o;
                b_n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic signed [15:0] d0, d1, d2);
        if (m[0]) data[0] = d0;
        if (m[1]) data[1] = d1;
        if (m[2]) data[2] = d2;
        vld = m;
        tick();
        vld = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        b_n = 0;
        tick();
    endtask

    initial begin
        rst = 1'b1; vld = '0; data = '0; ready = 1'b1; clr = 1'b0; b_n = 0;

        tbl[0].s = '{16'sd100, -16'sd200, 16'sd300};      tbl[0].mix = 18'sd200;
        tbl[1].s = '{16'sd32767, 16'sd32767, 16'sd32767}; tbl[1].mix = 18'sd98301;
        tbl[2].s = '{-16'sd32768, -16'sd32768, -16'sd32768}; tbl[2].mix = -18'sd98304;
        tbl[3].s = '{16'sd0, 16'sd0, 16'sd0};             tbl[3].mix = 18'sd0;
        tbl[4].s = '{-16'sd1, 16'sd1, -16'sd1};           tbl[4].mix = -18'sd1;

        do_reset();
        chk("rst_fv",  a_fv, 0);
        chk("rst_mix", a_mix, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_ovr", a_ovr, 0);
        chk("rst_tmo", a_tmo, 0);
        chk("rst_d0",  $signed(a_data[0]), 0);

        // Staggered channels at cycles 0/5/9.
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) drive(3'b001, 16'sd100, 16'sd0, 16'sd0);
            else if (c == 5) drive(3'b010, 16'sd0, -16'sd200, 16'sd0);
            else if (c == 9) begin
                push(16'sd100, -16'sd200, 16'sd300, 18'sd200);
                drive(3'b100, 16'sd0, 16'sd0, 16'sd300);
            end else tick();
            if (c == 8) chk("stag_fv_early", a_fv, 0);
            if (c == 9) begin
                chk("stag_fv",  a_fv, 1);
                chk("stag_mix", a_mix, 200);
                chk("stag_cnt", a_cnt, 1);
            end
        end

        // Table of simultaneous full frames with ready high.
        for (int k = 0; k < 5; k++) begin
            push(tbl[k].s[0], tbl[k].s[1], tbl[k].s[2], tbl[k].mix);
            drive(3'b111, tbl[k].s[0], tbl[k].s[1], tbl[k].s[2]);
            tick();
        end
        chk("tbl_cnt", a_cnt, 6);

        // Decimation by two on dut_b.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            logic signed [15:0] v;
            v = 16'(k);
            push(v, v, v, msum(v, v, v));
            drive(3'b111, v, v, v);
            tick();
        end
        tick();
        chk("dec_outputs", b_n, 2);
        chk("dec_mix0", b_mix[0], 3);
        chk("dec_mix1", b_mix[1], 9);
        chk("dec_cnt_b", b_cnt, 2);
        chk("dec_cnt_a", a_cnt, 4);
        chk("dec_ovr_b", b_ovr, 0);

        // Repeat on channel 0 before the frame completes.
        do_reset();
        drive(3'b001, 16'sd5, 16'sd0, 16'sd0);
        tick();
        drive(3'b001, 16'sd7, 16'sd0, 16'sd0);
        chk("rep_ovr", a_ovr, 1);
        push(16'sd7, 16'sd11, 16'sd22, msum(16'sd7, 16'sd11, 16'sd22));
        drive(3'b110, 16'sd0, 16'sd11, 16'sd22);
        chk("rep_slot0", $signed(a_data[0]), 7);
        tick();

        // Timeout with only channel 0, then a fresh frame.
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            if (c == 0) drive(3'b001, 16'sd99, 16'sd0, 16'sd0);
            else tick();
            if (c == 14) chk("tmo_early", a_tmo, 0);
            if (c == 15) chk("tmo_set", a_tmo, 1);
        end
        tick();
        drive(3'b110, 16'sd0, 16'sd2, 16'sd3);
        chk("tmo_stale_discard", a_fv, 0);
        push(16'sd1, 16'sd2, 16'sd3, 18'sd6);
        drive(3'b001, 16'sd1, 16'sd0, 16'sd0);
        chk("tmo_after_cnt", a_cnt, 1);
        chk("tmo_dec_kept_b", b_cnt, 1);
        chk("tmo_b_flag", b_tmo, 1);
        tick();

        // Backpressure: hold first frame, drop second; then no-bubble reload.
        do_reset();
        ready = 1'b0;
        push(16'sd10, 16'sd20, 16'sd30, 18'sd60);
        drive(3'b111, 16'sd10, 16'sd20, 16'sd30);
        tick();
        drive(3'b111, 16'sd40, 16'sd50, 16'sd60);
        chk("bp_ovr",  a_ovr, 1);
        chk("bp_fv",   a_fv, 1);
        chk("bp_held", $signed(a_data[0]), 10);
        chk("bp_cnt",  a_cnt, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_drained", a_fv, 0);
        push(16'sd1, 16'sd1, 16'sd1, 18'sd3);
        drive(3'b111, 16'sd1, 16'sd1, 16'sd1);
        ready = 1'b1;
        push(16'sd7, 16'sd7, 16'sd7, 18'sd21);
        drive(3'b111, 16'sd7, 16'sd7, 16'sd7);
        chk("nb_fv",  a_fv, 1);
        chk("nb_d0",  $signed(a_data[0]), 7);
        chk("nb_cnt", a_cnt, 3);
        tick();

        // Reset mid-COLLECT while a frame is held.
        ready = 1'b0;
        push(16'sd5, 16'sd6, 16'sd7, 18'sd18);
        drive(3'b111, 16'sd5, 16'sd6, 16'sd7);
        drive(3'b001, 16'sd9, 16'sd0, 16'sd0);
        chk("mr_pre_fv", a_fv, 1);
        rst = 1'b1;
        #1;
        chk("mr_fv",  a_fv, 0);
        chk("mr_mix", a_mix, 0);
        chk("mr_cnt", a_cnt, 0);
        chk("mr_ovr", a_ovr, 0);
        chk("mr_d0",  $signed(a_data[0]), 0);
        q.delete();
        tick();
        rst = 1'b0;
        ready = 1'b1;
        tick();
        drive(3'b110, 16'sd0, 16'sd8, 16'sd9);
        chk("mr_partial_gone", a_fv, 0);
        push(16'sd4, 16'sd8, 16'sd9, 18'sd21);
        drive(3'b001, 16'sd4, 16'sd0, 16'sd0);
        chk("mr_cnt_after", a_cnt, 1);
        tick();

        // Clear coincident with a new overrun: the set wins.
        drive(3'b001, 16'sd1, 16'sd0, 16'sd0);
        clr = 1'b1;
        drive(3'b001, 16'sd2, 16'sd0, 16'sd0);
        clr = 1'b0;
        chk("clr_vs_set", a_ovr, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_alone", a_ovr, 0);
        push(16'sd2, 16'sd3, 16'sd4, 18'sd9);
        drive(3'b110, 16'sd0, 16'sd3, 16'sd4);
        tick();
        tick();
        chk("sb_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mic_frame_aligner.md
MIC_FRAME_ALIGNER -- requirements
Module: mic_frame_aligner

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of mic channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 16: signed sample width.
REQ-003 SHALL have parameter DECIM, default 2: keep one of every DECIM complete frames (1..16; 1 = keep all).
REQ-004 SHALL have parameter TIMEOUT, default 4096: audio_clk cycles allowed to complete a partial frame.
REQ-005 SHALL have port audio_clk  in  1  the single clock for all logic.
REQ-006 SHALL have port rst_in  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ch_valid_in  in  NUM_CH  per-channel one-cycle sample strobe.
REQ-008 SHALL have port ch_data_in  in  NUM_CH x WIDTH  per-channel signed sample.
REQ-009 SHALL have port frame_ready_in  in  1  downstream accepts the frame.
REQ-010 SHALL have port frame_valid_out  out  1  aligned frame available.
REQ-011 SHALL have port frame_data_out  out  NUM_CH x WIDTH  aligned samples, channel i in slot i.
REQ-012 SHALL have port mix_out  out  WIDTH+clog2(NUM_CH)  signed sum of the frame's samples.
REQ-013 SHALL have port frame_count_out  out  16  frames loaded into the output register.
REQ-014 SHALL have port overrun_out  out  1  sticky: data lost to a repeat or to backpressure.
REQ-015 SHALL have port timeout_out  out  1  sticky: a partial frame was discarded.
REQ-016 SHALL have port clear_flags_in  in  1  clears both sticky flags.

Function
REQ-017 SHALL capture ch_data_in[i] and set got[i] on every cycle ch_valid_in[i] is high, all channels independently.
REQ-018 SHALL treat a ch_valid_in[i] while got[i] is set as a repeat: overwrite with the newest data and set overrun_out.
REQ-019 SHALL declare a frame complete on the cycle where got OR ch_valid_in covers all NUM_CH bits, using that cycle's data.
REQ-020 SHALL clear got and the timeout counter on completion; a valid in the cycle after completion starts the next frame.
REQ-021 SHALL keep a decimation counter 0..DECIM-1 advanced per complete frame; load the output only when the counter is 0, then wrap.
REQ-022 SHALL load frame_data_out and mix_out and assert frame_valid_out on the cycle after completion (latency 1).
REQ-023 SHALL compute mix_out as a sign-extended full-precision sum with no saturation.
REQ-024 SHALL hold frame_valid_out and the data stable until frame_valid_out and frame_ready_in are both high.
REQ-025 SHALL load a new frame when the output is empty or accepted in the same cycle, without a bubble.
REQ-026 SHALL drop a kept frame arriving while the held frame is not accepted, keep the held frame, and set overrun_out.
REQ-027 SHALL increment frame_count_out modulo 2^16 on each output load only.
REQ-028 SHALL count cycles while got is nonzero; at TIMEOUT-1 without completion, discard got, set timeout_out, and leave the decimation counter unchanged.
REQ-029 SHALL give a flag set event priority over clear_flags_in in the same cycle.
REQ-030 SHALL, for a state machine of IDLE (got empty), COLLECT (partial), and TIMEOUT_FLUSH (one cycle, back to IDLE), go IDLE->COLLECT on a partial valid and COLLECT/IDLE->IDLE on completion.

Reset
REQ-031 SHALL, on rst_in, clear immediately: frame_valid_out=0, frame_data_out=0, mix_out=0, frame_count_out=0, overrun_out=0, timeout_out=0, got=0, counters=0, state IDLE.
REQ-032 SHALL discard any partial or held frame when reset asserts mid-operation, and produce no output until a full frame completes after release.

Structure
REQ-033 SHALL place the state enum and a sample-array typedef (NUM_CH x WIDTH signed) in shared package audio_pkg.
REQ-034 SHALL use one sub-module, frame_mixer: a registered signed adder tree producing mix_out aligned with frame_data_out.

Verification
REQ-035 SHALL test NUM_CH=3, DECIM=1: valids for ch0/1/2 at cycles 0/5/9 with data 100/-200/300 -> frame_valid_out at cycle 10, mix_out=200, frame_count_out=1.
REQ-036 SHALL test DECIM=2: four complete frames with ready tied high -> only frames 1 and 3 are output, frame_count_out=2.
REQ-037 SHALL test a repeat: ch0 valid twice (5 then 7) before ch1/ch2 -> slot 0 holds 7 and overrun_out=1.
REQ-038 SHALL test TIMEOUT=16: only ch0 valid -> timeout_out=1 at cycle 16; a later full frame is output normally.
REQ-039 SHALL test backpressure: ready low across two kept frames -> the first is held, the second dropped, overrun_out=1; the same-cycle ready+new-frame case loads with no bubble.
REQ-040 SHALL test reset: rst_in mid-COLLECT with frame_valid_out high -> all outputs 0 at once, and clear_flags_in coincident with a new overrun leaves overrun_out=1.
